// File: rtl/led_blink_pkg.sv
// Shared types and encodings for the LED indicator array.
// Build option: define BLINK_PWM_EN for duty-cycle blink (see blink_channel).
package led_blink_pkg;

  // Channel operating mode, encoded exactly as the cfg_mode write field.
  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic [1:0] MODE_ENC_OFF     = 2'b00;
  localparam logic [1:0] MODE_ENC_ON      = 2'b01;
  localparam logic [1:0] MODE_ENC_BLINK   = 2'b10;
  localparam logic [1:0] MODE_ENC_ONESHOT = 2'b11;

  // Width of a select field addressing n items (never narrower than one bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: mode/period/phase registers plus the tick-driven FSM.
// With BLINK_PWM_EN defined, BLINK becomes a PWM output using a duty register;
// otherwise the duty input is unused and BLINK toggles at 50 %.
module blink_channel
  import led_blink_pkg::*;
#(
  parameter int unsigned PER_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  mode_e            i_mode,
  input  logic [PER_W-1:0] i_period,
  input  logic [PER_W-1:0] i_duty,
  input  logic             i_tick,
  output logic             o_led,
  output logic             o_done
);

  localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

  mode_e            r_mode, w_mode_nxt;
  logic [PER_W-1:0] r_period, w_period_nxt;
  logic [PER_W-1:0] r_phase, w_phase_nxt;
  logic             r_led, w_led_nxt;
  logic             r_done, w_done_nxt;
  logic [PER_W-1:0] w_phase_inc;
  logic             w_last;

`ifdef BLINK_PWM_EN
  logic [PER_W-1:0] r_duty, w_duty_nxt;
`else
  logic             w_unused_duty;
  assign w_unused_duty = ^i_duty;
`endif

  // Period is stored normalised (never 0), so period-1 is always a valid phase.
  assign w_last      = (r_phase == (r_period - PER_ONE));
  assign w_phase_inc = w_last ? '0 : (r_phase + PER_ONE);

  // Next-state: a write overrides any tick arriving in the same cycle.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_period_nxt = r_period;
    w_phase_nxt  = r_phase;
    w_led_nxt    = r_led;
    w_done_nxt   = 1'b0;
`ifdef BLINK_PWM_EN
    w_duty_nxt   = r_duty;
`endif
    if (i_we) begin
      w_mode_nxt   = i_mode;
      w_period_nxt = (i_period == '0) ? PER_ONE : i_period;
      w_phase_nxt  = '0;
      w_led_nxt    = (i_mode != MODE_OFF);
`ifdef BLINK_PWM_EN
      w_duty_nxt   = i_duty;
      // PWM blink starts at phase 0, so it is lit only if duty is non-zero.
      if (i_mode == MODE_BLINK) begin
        w_led_nxt = (i_duty != '0);
      end
`endif
    end else if (i_tick) begin
      case (r_mode)
        MODE_BLINK: begin
          w_phase_nxt = w_phase_inc;
`ifdef BLINK_PWM_EN
          w_led_nxt   = (w_phase_inc < r_duty);
`else
          if (w_last) begin
            w_led_nxt = ~r_led;
          end
`endif
        end
        MODE_ONESHOT: begin
          w_phase_nxt = w_phase_inc;
          if (w_last) begin
            w_led_nxt  = 1'b0;
            w_mode_nxt = MODE_OFF;
            w_done_nxt = 1'b1;
          end
        end
        default: begin
          // OFF and ON hold their LED and ignore ticks.
        end
      endcase
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= MODE_OFF;
      r_period <= PER_ONE;
      r_phase  <= '0;
      r_led    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_period <= w_period_nxt;
      r_phase  <= w_phase_nxt;
      r_led    <= w_led_nxt;
      r_done   <= w_done_nxt;
    end
  end

`ifdef BLINK_PWM_EN
  // Duty register exists only in the PWM build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
    end else begin
      r_duty <= w_duty_nxt;
    end
  end
`endif

  assign o_led  = r_led;
  assign o_done = r_done;

endmodule

// File: rtl/led_blink_array.sv
// Multi-channel LED indicator: shared tick prescaler, write decode and NUM_CH
// blink_channel instances. Build option BLINK_PWM_EN selects PWM blink.
module led_blink_array
  import led_blink_pkg::*;
#(
  parameter int unsigned PRESCALE = 6000,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PER_W    = 10,
  localparam int unsigned CH_W    = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_we,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [1:0]        i_cfg_mode,
  input  logic [PER_W-1:0]  i_cfg_period,
  input  logic [PER_W-1:0]  i_cfg_duty,
  output logic              o_tick,
  output logic [NUM_CH-1:0] o_done,
  output logic [NUM_CH-1:0] o_led
);

  localparam int unsigned      CNT_W   = sel_width(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_MAX);

  // Free-running prescaler; tick is registered so it pulses the cycle after the wrap value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : (r_cnt + CNT_W'(1));
      r_tick <= w_wrap;
    end
  end

  assign o_tick = r_tick;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_we;

    // Equality decode: any cfg_ch code without a matching channel selects nothing.
    assign w_we = i_cfg_we && (i_cfg_ch == CH_W'(g));

    blink_channel #(
      .PER_W (PER_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_we),
      .i_mode   (mode_e'(i_cfg_mode)),
      .i_period (i_cfg_period),
      .i_duty   (i_cfg_duty),
      .i_tick   (r_tick),
      .o_led    (o_led[g]),
      .o_done   (o_done[g])
    );
  end

endmodule

// File: tb/tb_led_blink_array.sv
// Self-checking bench for led_blink_array. NUM_CH=3 so that cfg_ch=3 is a
// representable out-of-range channel code on the 2-bit select.
module tb_led_blink_array;

  localparam int unsigned PRE = 4;
  localparam int unsigned NCH = 3;
  localparam int unsigned PW  = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [1:0]     cfg_mode = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic [PW-1:0]  cfg_duty = '0;
  logic           tick;
  logic [NCH-1:0] done;
  logic [NCH-1:0] led;

  int n_vec = 0;
  int n_err = 0;

  led_blink_array #(
    .PRESCALE (PRE),
    .NUM_CH   (NCH),
    .PER_W    (PW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_we     (cfg_we),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_mode   (cfg_mode),
    .i_cfg_period (cfg_period),
    .i_cfg_duty   (cfg_duty),
    .o_tick       (tick),
    .o_done       (done),
    .o_led        (led)
  );

  always #5 clk = ~clk;

  // Behavioural model: LED state derived from the number of ticks since the last write.
  int             m_mode [NCH];
  int             m_per  [NCH];
  int             m_duty [NCH];
  int             m_n    [NCH];
  logic [NCH-1:0] m_led  = '0;
  logic [NCH-1:0] m_done = '0;
  logic           m_tick = 1'b0;
  int             m_k    = 0;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_per[c] = 1; m_duty[c] = 0; m_n[c] = 0;
    end
    m_led = '0; m_done = '0; m_tick = 1'b0; m_k = 0;
  endtask

  task automatic model_step();
    logic tick_prev;
    tick_prev = m_tick;
    m_done = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg_we && int'(cfg_ch) == c) begin
        m_mode[c] = int'(cfg_mode);
        m_per[c]  = (cfg_period == '0) ? 1 : int'(cfg_period);
        m_duty[c] = int'(cfg_duty);
        m_n[c]    = 0;
        m_led[c]  = (m_mode[c] != 0);
`ifdef BLINK_PWM_EN
        if (m_mode[c] == 2) m_led[c] = (m_duty[c] > 0);
`endif
      end else if (tick_prev) begin
        if (m_mode[c] == 2) begin
          m_n[c]++;
`ifdef BLINK_PWM_EN
          m_led[c] = ((m_n[c] % m_per[c]) < m_duty[c]);
`else
          m_led[c] = (((m_n[c] / m_per[c]) % 2) == 0);
`endif
        end else if (m_mode[c] == 3) begin
          m_n[c]++;
          if (m_n[c] == m_per[c]) begin
            m_led[c] = 1'b0; m_mode[c] = 0; m_done[c] = 1'b1;
          end
        end
      end
    end
    m_k++;
    m_tick = ((m_k % PRE) == 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Advance to the next falling edge and compare every output with the model.
  task automatic cyc();
    @(negedge clk);
    n_vec++;
    if (tick !== m_tick || led !== m_led || done !== m_done) begin
      n_err++;
      $display("FAIL model t=%0t: tick/led/done got %b/%b/%b want %b/%b/%b",
               $time, tick, led, done, m_tick, m_led, m_done);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                    input logic [PW-1:0] per, input logic [PW-1:0] duty);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_period = per; cfg_duty = duty;
    cyc();
    cfg_we = 1'b0;
  endtask

  // Count n ticks (including one visible now), then step to the cycle they take effect.
  task automatic wait_ticks(input int n);
    int seen;
    int budget;
    seen = 0; budget = 0;
    while (seen < n) begin
      if (tick) seen++;
      if (seen < n) begin
        cyc();
        budget++;
        if (budget > 100) begin
          n_vec++; n_err++;
          $display("FAIL tick_timeout t=%0t: got %0d ticks want %0d", $time, seen, n);
          return;
        end
      end
    end
    cyc();
  endtask

  task automatic align_tick();
    int budget;
    budget = 0;
    while (!tick && budget < 20) begin
      cyc();
      budget++;
    end
    chk("align_tick", {7'd0, tick}, 8'd1);
  endtask

  logic [8:0] tick_pat;

  initial begin
    // Reset and prescaler cadence.
    repeat (3) cyc();
    chk("rst_led", {5'd0, led}, 8'h00);
    chk("rst_done", {5'd0, done}, 8'h00);
    chk("rst_tick", {7'd0, tick}, 8'h00);
    rst_n = 1'b1;
    tick_pat = 9'b010001000;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("tick_cadence", {7'd0, tick}, {7'd0, tick_pat[i-1]});
    end

    // BLINK ch0, period 3.
    wr(2'd0, 2'b10, 4'd3, 4'd0);
`ifndef BLINK_PWM_EN
    chk("blink_start", {5'd0, led}, 8'h01);
    wait_ticks(2);
    chk("blink_hold", {7'd0, led[0]}, 8'd1);
    wait_ticks(1);
    chk("blink_off", {5'd0, led}, 8'h00);
    wait_ticks(3);
    chk("blink_on", {7'd0, led[0]}, 8'd1);
`endif

    // ONESHOT ch1, period 5.
    wr(2'd1, 2'b11, 4'd5, 4'd0);
    chk("os_start", {7'd0, led[1]}, 8'd1);
    wait_ticks(4);
    chk("os_lit", {7'd0, led[1]}, 8'd1);
    chk("os_nodone", {7'd0, done[1]}, 8'd0);
    wait_ticks(1);
    chk("os_end_led", {7'd0, led[1]}, 8'd0);
    chk("os_done", {5'd0, done}, 8'h02);
    cyc();
    chk("os_done_clr", {7'd0, done[1]}, 8'd0);
    repeat (10) cyc();

    // Writes coinciding with a tick: the tick is ignored for that channel.
    align_tick();
    wr(2'd2, 2'b01, 4'd1, 4'd0);
    chk("on_at_tick", {7'd0, led[2]}, 8'd1);
    align_tick();
    wr(2'd1, 2'b11, 4'd2, 4'd0);
    wait_ticks(1);
    chk("os_tick_ignored", {7'd0, led[1]}, 8'd1);
    wait_ticks(1);
    chk("os2_done", {7'd0, done[1]}, 8'd1);

    // Out-of-range channel write changes nothing.
    wr(2'd3, 2'b01, 4'd1, 4'd0);
    repeat (2) cyc();
    chk("oor_led1", {7'd0, led[1]}, 8'd0);

    // Restarting a running ONESHOT: no done for the aborted pulse.
    wr(2'd1, 2'b11, 4'd5, 4'd0);
    wait_ticks(3);
    wr(2'd1, 2'b11, 4'd2, 4'd0);
    wait_ticks(1);
    chk("restart_nodone", {7'd0, done[1]}, 8'd0);
    wait_ticks(1);
    chk("restart_done", {7'd0, done[1]}, 8'd1);

    // Period 0 behaves as period 1.
    wr(2'd2, 2'b10, 4'd0, 4'd0);
`ifndef BLINK_PWM_EN
    wait_ticks(1);
    chk("per0_toggle", {7'd0, led[2]}, 8'd0);
    wait_ticks(1);
    chk("per0_toggle2", {7'd0, led[2]}, 8'd1);
`endif

    // Asynchronous reset in the middle of BLINK and ONESHOT.
    wr(2'd0, 2'b10, 4'd3, 4'd3);
    wr(2'd1, 2'b11, 4'd9, 4'd0);
    repeat (3) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_led", {5'd0, led}, 8'h00);
    chk("arst_done", {5'd0, done}, 8'h00);
    chk("arst_tick", {7'd0, tick}, 8'h00);
    repeat (2) cyc();
    rst_n = 1'b1;
    repeat (12) cyc();
    chk("post_rst_off", {5'd0, led}, 8'h00);

`ifdef BLINK_PWM_EN
    // PWM blink, period 4 with duty 1, 0 and 5.
    wr(2'd0, 2'b10, 4'd4, 4'd1);
    chk("pwm1_start", {7'd0, led[0]}, 8'd1);
    wait_ticks(1);
    chk("pwm1_low", {7'd0, led[0]}, 8'd0);
    wait_ticks(3);
    chk("pwm1_high", {7'd0, led[0]}, 8'd1);
    wr(2'd0, 2'b10, 4'd4, 4'd0);
    chk("pwm0_start", {7'd0, led[0]}, 8'd0);
    wait_ticks(4);
    chk("pwm0_off", {7'd0, led[0]}, 8'd0);
    wr(2'd0, 2'b10, 4'd4, 4'd5);
    wait_ticks(4);
    chk("pwm5_on", {7'd0, led[0]}, 8'd1);
`endif

    repeat (8) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
